// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load.
// Contents are registered; q has no combinational path from any input.
module universal_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  output logic [WIDTH-1:0] q
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_next;

  // Shifts are logical; callers build rotates by looping q back in.
  always_comb begin
    q_next = q;
    unique case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHR:  q_next = {serial_in_left, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], serial_in_right};
      MODE_LOAD: q_next = data_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg.
// Vector table, rotate sequence and random run share one scoreboard queue.
module tb_universal_shift_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic [W-1:0] data_in;
  logic         serial_in_left;
  logic         serial_in_right;
  logic [W-1:0] q;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .mode            (mode),
    .data_in         (data_in),
    .serial_in_left  (serial_in_left),
    .serial_in_right (serial_in_right),
    .q               (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         sl;
    logic         sr;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] sb_q[$];
  string        sb_n[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model;

  function automatic vec_t mk(logic r, logic [1:0] m, logic [W-1:0] d,
                              logic sl, logic sr, logic [W-1:0] e,
                              string n);
    vec_t v;
    v.rst = r; v.mode = m; v.d = d;
    v.sl = sl; v.sr = sr; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic step(logic r, logic [1:0] m, logic [W-1:0] d,
                      logic sl, logic sr, logic [W-1:0] e,
                      string n);
    logic [W-1:0] got_e;
    string        got_n;
    @(negedge clk);
    rst = r; mode = m; data_in = d;
    serial_in_left = sl; serial_in_right = sr;
    sb_q.push_back(e);
    sb_n.push_back(n);
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, q=%b", n, q);
    end else begin
      got_e = sb_q.pop_front();
      got_n = sb_n.pop_front();
      if (q !== got_e) begin
        errors++;
        $display("FAIL %s: q=%b expected %b", got_n, q, got_e);
      end
    end
    model = e;
  endtask

  function automatic logic [W-1:0] ref_next(logic r, logic [1:0] m,
                                            logic [W-1:0] cur,
                                            logic [W-1:0] d,
                                            logic sl, logic sr);
    if (r) return '0;
    case (m)
      2'b00:   return cur;
      2'b01:   return {sl, cur[W-1:1]};
      2'b10:   return {cur[W-2:0], sr};
      default: return d;
    endcase
  endfunction

  initial begin
    rst = 1'b1; mode = 2'b00; data_in = '0;
    serial_in_left = 1'b0; serial_in_right = 1'b0;
    model = '0;

    vecs.push_back(mk(1, 2'b00, 4'b0000, 0, 0, 4'b0000, "reset"));
    vecs.push_back(mk(1, 2'b11, 4'b1111, 1, 1, 4'b0000, "reset_prio"));
    vecs.push_back(mk(0, 2'b11, 4'b1010, 0, 0, 4'b1010, "load_a"));
    vecs.push_back(mk(0, 2'b01, 4'b1111, 1, 0, 4'b1101, "shr_in1"));
    vecs.push_back(mk(0, 2'b01, 4'b0000, 0, 1, 4'b0110, "shr_0a"));
    vecs.push_back(mk(0, 2'b01, 4'b1111, 0, 1, 4'b0011, "shr_0b"));
    vecs.push_back(mk(0, 2'b01, 4'b0000, 0, 0, 4'b0001, "shr_0c"));
    vecs.push_back(mk(0, 2'b01, 4'b0101, 0, 1, 4'b0000, "shr_0d"));
    vecs.push_back(mk(0, 2'b11, 4'b1101, 0, 0, 4'b1101, "load_d"));
    vecs.push_back(mk(0, 2'b10, 4'b0000, 1, 0, 4'b1010, "shl_in0"));
    vecs.push_back(mk(0, 2'b11, 4'b0000, 0, 0, 4'b0000, "load_0"));
    vecs.push_back(mk(0, 2'b10, 4'b1010, 0, 1, 4'b0001, "shl_1a"));
    vecs.push_back(mk(0, 2'b10, 4'b0000, 1, 1, 4'b0011, "shl_1b"));
    vecs.push_back(mk(0, 2'b10, 4'b0110, 0, 1, 4'b0111, "shl_1c"));
    vecs.push_back(mk(0, 2'b10, 4'b0000, 1, 1, 4'b1111, "shl_1d"));
    vecs.push_back(mk(0, 2'b11, 4'b1010, 0, 0, 4'b1010, "load_a2"));
    vecs.push_back(mk(0, 2'b00, 4'b0101, 1, 1, 4'b1010, "hold_1"));
    vecs.push_back(mk(0, 2'b00, 4'b1111, 0, 0, 4'b1010, "hold_2"));
    vecs.push_back(mk(0, 2'b00, 4'b0000, 1, 0, 4'b1010, "hold_3"));

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].mode, vecs[i].d,
           vecs[i].sl, vecs[i].sr, vecs[i].exp, vecs[i].name);

    // reset in the middle of a shift run, then reload
    step(0, 2'b11, 4'b1101, 0, 0, 4'b1101, "mid_load");
    step(0, 2'b01, 4'b0000, 1, 0, 4'b1110, "mid_shr");
    step(1, 2'b01, 4'b1111, 1, 1, 4'b0000, "mid_rst");
    step(0, 2'b11, 4'b0101, 0, 0, 4'b0101, "post_rst_load");

    // external rotate right: q[0] fed back to serial_in_left
    step(0, 2'b11, 4'b1001, 0, 0, 4'b1001, "rot_load");
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = {model[0], model[W-1:1]};
      step(0, 2'b01, 4'b0000, q[0], 1'b0, e, "rotr");
    end
    // external rotate left: q[W-1] fed back to serial_in_right
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e;
      e = {model[W-2:0], model[W-1]};
      step(0, 2'b10, 4'b0000, 1'b0, q[W-1], e, "rotl");
    end

    // random traffic against a reference model
    for (int i = 0; i < 60; i++) begin
      logic         r, sl, sr;
      logic [1:0]   m;
      logic [W-1:0] d;
      r  = ($urandom_range(0, 15) == 0);
      m  = 2'($urandom_range(0, 3));
      d  = W'($urandom);
      sl = 1'($urandom);
      sr = 1'($urandom);
      step(r, m, d, sl, sr, ref_next(r, m, model, d, sl, sr), "random");
    end

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
